// File: rtl/irq_pending_if.sv
// Request/service bus between irq_pending and its priority-encoder consumer.
// Parameter N sets the number of request lines; W is the ack_pos width.
interface irq_pending_if #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic [N-1:0] snap;
    logic         valid;
    logic         ack;
    logic [W-1:0] ack_pos;
    logic         ack_err;
    logic [N-1:0] ovf;

    // Handshake: valid=1 means snap is frozen and non-zero. A transfer occurs on a
    // posedge where valid && ack && snap[ack_pos]. That transfer clears the serviced
    // bit and drops valid for at least one cycle. Any other ack produces a
    // one-cycle ack_err pulse and no other effect.
    modport master (
        output req, mask, ack, ack_pos,
        input  snap, valid, ack_err, ovf
    );

    modport slave (
        input  req, mask, ack, ack_pos,
        output snap, valid, ack_err, ovf
    );
endinterface

// File: rtl/irq_pending.sv
// Request latch and snapshot stage that feeds a lowest-index priority encoder.
// Optional per-line overflow tracking is enabled by defining IRQ_OVERFLOW_EN.
module irq_pending #(
    parameter int N    = 8,
    parameter int EDGE = 1
) (
    input  logic         clk,
    input  logic         rst,
    irq_pending_if.slave bus,
    output logic         dbg_state,
    output logic [N-1:0] dbg_pending
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam int P = 1 << W;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] req_d;
    logic [N-1:0] pending;
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic [N-1:0] eligible;
    logic [N-1:0] snap_q;
    logic [N-1:0] ovf_q;
    logic [P-1:0] snap_ext;
    logic [P-1:0] clr_ext;
    logic         snap_bit;
    logic         snap_load;
    logic         valid;
    logic         ack_hit;
    logic         ack_err_next;
    logic         ack_err_q;

    // Set term and presentation mask.
    always_comb begin
        set = bus.req;
        if (EDGE != 0) begin
            set = bus.req & ~req_d;
        end
        eligible = pending & ~bus.mask;
    end

    // Out-of-range ack_pos reads a zero pad bit, so it is reported as an error.
    always_comb begin
        snap_ext         = '0;
        snap_ext[N-1:0]  = snap_q;
        snap_bit         = snap_ext[bus.ack_pos];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.ack && snap_bit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        valid        = (state == REQ);
        snap_load    = (state == IDLE) && (|eligible);
        ack_hit      = bus.ack && valid && snap_bit;
        ack_err_next = bus.ack && !ack_hit;
        clr_ext      = '0;
        clr_ext[bus.ack_pos] = ack_hit;
        clr          = clr_ext[N-1:0];
    end

    // A line already high across reset is not a fresh edge, so req_d keeps tracking.
    always_ff @(posedge clk) begin
        req_d <= bus.req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            snap_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            pending   <= (pending & ~clr) | set;
            ack_err_q <= ack_err_next;
            if (snap_load) begin
                snap_q <= eligible;
            end
        end
    end

`ifdef IRQ_OVERFLOW_EN
    // A set landing on a still-pending, not-being-cleared bit loses a request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~clr) | (set & pending & ~clr);
        end
    end
`else
    assign ovf_q = '0;
`endif

    assign bus.snap    = snap_q;
    assign bus.valid   = valid;
    assign bus.ack_err = ack_err_q;
    assign bus.ovf     = ovf_q;
    assign dbg_state   = state;
    assign dbg_pending = pending;

    snap_stable_in_req: assert property (
        @(posedge clk) disable iff (rst)
        (state == REQ && $past(state) == REQ && !$past(rst)) |-> $stable(snap_q)
    );

    valid_implies_snap: assert property (
        @(posedge clk) disable iff (rst)
        valid |-> (|snap_q)
    );
endmodule
